mux_operaciones: RTL and testbench

MUX_OPERACIONES -- requirements
Module: mux_operaciones

---
 rtl/mux_operaciones.sv | 121 ++++++++++++
 tb/tb_mux_operaciones.sv | 112 +++++++++++
 2 files changed

// File: rtl/mux_operaciones.sv
// Registered arithmetic/logic unit with a seven-segment view of the low result nibble.
// Each edge loads one result from that cycle's operands; there is no accumulation.
module mux_operaciones #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   selector,
  input  logic         operacion,
  output logic [N:0]   out,
  output logic [6:0]   deco
);

  localparam logic [N-1:0] WIDTH_AMT = N[N-1:0];
  localparam logic [N:0]   ZERO_RES  = {(N+1){1'b0}};
  localparam logic [6:0]   SEG_ZERO  = 7'b1000000;

  logic [N:0] out_q;
  logic [N:0] out_d;
  logic [6:0] deco_q;
  logic [6:0] deco_d;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Sign-filling right shift; oversized amounts saturate to all sign bits.
  function automatic logic [N-1:0] shift_ra(input logic [N-1:0] a, input logic [N-1:0] amt);
    logic [N-1:0] r;
    if (amt >= WIDTH_AMT) begin
      r = {N{a[N-1]}};
    end else begin
      r = $signed(a) >>> amt;
    end
    return r;
  endfunction

  // Zero-filling right shift; oversized amounts give zero.
  function automatic logic [N-1:0] shift_rl(input logic [N-1:0] a, input logic [N-1:0] amt);
    logic [N-1:0] r;
    if (amt >= WIDTH_AMT) begin
      r = {N{1'b0}};
    end else begin
      r = a >> amt;
    end
    return r;
  endfunction

  // Zero-filling left shift; arithmetic and logical left shifts are identical.
  function automatic logic [N-1:0] shift_l(input logic [N-1:0] a, input logic [N-1:0] amt);
    logic [N-1:0] r;
    if (amt >= WIDTH_AMT) begin
      r = {N{1'b0}};
    end else begin
      r = a << amt;
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rot_r1(input logic [N-1:0] a);
    return {a[0], a[N-1:1]};
  endfunction

  // Next result selection; only addition drives the carry bit.
  always_comb begin
    out_d = ZERO_RES;
    case ({operacion, selector})
      4'b1_000: out_d = {1'b0, A} + {1'b0, B};
      4'b1_001: out_d = {1'b0, A - B};
      4'b1_010: out_d = {1'b0, shift_ra(A, B)};
      4'b1_011: out_d = {1'b0, shift_l(A, B)};
      4'b1_100: out_d = {1'b0, rot_r1(A)};
      4'b0_000: out_d = {1'b0, A & B};
      4'b0_001: out_d = {1'b0, A | B};
      4'b0_010: out_d = {1'b0, A ^ B};
      4'b0_011: out_d = {1'b0, shift_rl(A, B)};
      4'b0_100: out_d = {1'b0, shift_l(A, B)};
      4'b0_101: out_d = {1'b0, rot_r1(A)};
      default:  out_d = ZERO_RES;
    endcase
    deco_d = seg7(out_d[3:0]);
  end

  // Result and display registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= ZERO_RES;
      deco_q <= SEG_ZERO;
    end else begin
      out_q  <= out_d;
      deco_q <= deco_d;
    end
  end

  assign out  = out_q;
  assign deco = deco_q;

endmodule

// File: tb/tb_mux_operaciones.sv
// Directed-vector bench for mux_operaciones (N=4) with hand-computed results.
module tb_mux_operaciones;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] selector;
  logic       operacion;
  logic [4:0] out;
  logic [6:0] deco;

  int errors = 0;
  int checks = 0;

  mux_operaciones #(.N(4)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B),
    .selector(selector), .operacion(operacion),
    .out(out), .deco(deco)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Seven-segment patterns transcribed from the display table.
  function automatic logic [6:0] seg_exp(input logic [3:0] v);
    logic [6:0] t [16];
    t[0]  = 7'b1000000; t[1]  = 7'b1111001; t[2]  = 7'b0100100; t[3]  = 7'b0110000;
    t[4]  = 7'b0011001; t[5]  = 7'b0010010; t[6]  = 7'b0000010; t[7]  = 7'b1111000;
    t[8]  = 7'b0000000; t[9]  = 7'b0010000; t[10] = 7'b0001000; t[11] = 7'b0000011;
    t[12] = 7'b1000110; t[13] = 7'b0100001; t[14] = 7'b0000110; t[15] = 7'b0001110;
    return t[v];
  endfunction

  task automatic run(input string tag, input logic op, input logic [2:0] sel,
                     input logic [3:0] a, input logic [3:0] b, input logic [4:0] exp);
    operacion = op; selector = sel; A = a; B = b;
    @(posedge clk); #1;
    check({tag, ".out"}, {11'd0, out}, {11'd0, exp});
    check({tag, ".deco"}, {9'd0, deco}, {9'd0, seg_exp(exp[3:0])});
  endtask

  initial begin
    rst = 1'b1; A = 4'd0; B = 4'd0; selector = 3'd0; operacion = 1'b1;
    @(posedge clk); #1;
    check("reset.out", {11'd0, out}, 16'h0000);
    check("reset.deco", {9'd0, deco}, {9'd0, 7'b1000000});
    rst = 1'b0;

    run("add_ff", 1'b1, 3'b000, 4'b1111, 4'b1111, 5'b11110);
    run("add_55", 1'b1, 3'b000, 4'b0101, 4'b0101, 5'b01010);
    run("sub_6a", 1'b1, 3'b001, 4'b0110, 4'b1010, 5'b01100);
    run("sub_0f", 1'b1, 3'b001, 4'b0000, 4'b1111, 5'b00001);
    run("sub_ff", 1'b1, 3'b001, 4'b1111, 4'b1111, 5'b00000);
    run("sra_1",  1'b1, 3'b010, 4'b1010, 4'd1, 5'b01101);
    run("sra_2",  1'b1, 3'b010, 4'b1010, 4'd2, 5'b01110);
    run("sra_3",  1'b1, 3'b010, 4'b1010, 4'd3, 5'b01111);
    run("sra_9",  1'b1, 3'b010, 4'b1010, 4'd9, 5'b01111);
    run("sra_pos",1'b1, 3'b010, 4'b0110, 4'd1, 5'b00011);
    run("sla_1",  1'b1, 3'b011, 4'b1010, 4'd1, 5'b00100);
    run("sla_2",  1'b1, 3'b011, 4'b1010, 4'd2, 5'b01000);
    run("sla_3",  1'b1, 3'b011, 4'b1010, 4'd3, 5'b00000);
    run("sla_4",  1'b1, 3'b011, 4'b0001, 4'd4, 5'b00000);
    run("rot1_1", 1'b1, 3'b100, 4'b0001, 4'd7, 5'b01000);
    run("rot1_a", 1'b1, 3'b100, 4'b1010, 4'd3, 5'b00101);
    run("and",    1'b0, 3'b000, 4'b0101, 4'b1101, 5'b00101);
    run("or",     1'b0, 3'b001, 4'b0001, 4'b1001, 5'b01001);
    run("xor",    1'b0, 3'b010, 4'b0001, 4'b1001, 5'b01000);
    run("srl_2",  1'b0, 3'b011, 4'b1010, 4'd2, 5'b00010);
    run("srl_4",  1'b0, 3'b011, 4'b1111, 4'd4, 5'b00000);
    run("sll_1",  1'b0, 3'b100, 4'b0100, 4'd1, 5'b01000);
    run("sll_7",  1'b0, 3'b100, 4'b0011, 4'd7, 5'b00000);
    run("rot0_1", 1'b0, 3'b101, 4'b0001, 4'd15, 5'b01000);
    run("rot0_a", 1'b0, 3'b101, 4'b1010, 4'd0, 5'b00101);
    run("nop1_5", 1'b1, 3'b101, 4'b1111, 4'b1111, 5'b00000);
    run("nop1_7", 1'b1, 3'b111, 4'b1111, 4'b1111, 5'b00000);
    run("nop0_6", 1'b0, 3'b110, 4'b1111, 4'b0001, 5'b00000);
    run("nop0_7", 1'b0, 3'b111, 4'b1001, 4'b0110, 5'b00000);

    // Reset mid-stream discards the pending result.
    run("pre_rst", 1'b0, 3'b001, 4'b0011, 4'b0100, 5'b00111);
    operacion = 1'b1; selector = 3'b000; A = 4'b1001; B = 4'b0100;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst.out", {11'd0, out}, 16'h0000);
    check("midrst.deco", {9'd0, deco}, {9'd0, 7'b1000000});
    rst = 1'b0;
    @(posedge clk); #1;
    check("postrst.out", {11'd0, out}, {11'd0, 5'b01101});
    check("postrst.deco", {9'd0, deco}, {9'd0, 7'b0100001});

    // Latency: new inputs must not show before the next edge.
    operacion = 1'b0; selector = 3'b010; A = 4'b1100; B = 4'b0101;
    #3;
    check("lat.hold", {11'd0, out}, {11'd0, 5'b01101});
    @(posedge clk); #1;
    check("lat.load", {11'd0, out}, {11'd0, 5'b01001});
    check("lat.deco", {9'd0, deco}, {9'd0, 7'b0010000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
